core_temp_monitor: RTL and testbench

Per-core thermal sample conditioner that sits directly upstream of the SoC controller and drives its per-core temperature sensor inputs. Raw sensor codes arrive on a per-core valid/ready handshake and land in one-entry holding registers. A single shared update datapath, served round-robin, applies an exponential moving average to each held sample. Per core, the block produces a filtered temperature, a hot flag with hysteresis and an optional stale-sensor flag.

---
 rtl/soc_pkg.sv | 17 +
 rtl/core_temp_monitor_if.sv | 15 +
 rtl/core_temp_rr_arb.sv | 40 ++++
 rtl/core_temp_monitor.sv | 108 ++++++++++
 tb/tb_core_temp_monitor.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_pkg.sv
// Shared SoC thermal types and default thresholds, plus the hot-flag hysteresis rule.
package soc_pkg;

  localparam int TEMP_SENSOR_WIDTH  = 10;
  localparam int DEFAULT_HOT_THRESH = 800;
  localparam int DEFAULT_HOT_HYST   = 32;

  typedef logic [TEMP_SENSOR_WIDTH-1:0] temp_t;

  function automatic logic hot_next(input logic cur, input logic at_or_above_on,
                                    input logic below_off);
    if (at_or_above_on) return 1'b1;
    if (below_off)      return 1'b0;
    return cur;
  endfunction

endpackage

// File: rtl/core_temp_monitor_if.sv
// Per-core raw sample handshake. A sample transfers on a rising edge where
// sample_valid[c] & sample_ready[c]; sample_ready depends only on slave state.
interface core_temp_monitor_if #(
  parameter int NUM_CORE = 4,
  parameter int W        = soc_pkg::TEMP_SENSOR_WIDTH
);

  logic [NUM_CORE-1:0]        sample_valid;
  logic [NUM_CORE-1:0][W-1:0] sample;
  logic [NUM_CORE-1:0]        sample_ready;

  modport master (output sample_valid, output sample, input  sample_ready);
  modport slave  (input  sample_valid, input  sample, output sample_ready);

endinterface

// File: rtl/core_temp_rr_arb.sv
// Round-robin arbiter: search starts one past the last grant and wraps; owns the pointer.
module core_temp_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid
);

  logic [IDX_W-1:0] ptr;
  int               cand;

  always_comb begin
    grant       = '0;
    grant_idx   = ptr;
    grant_valid = 1'b0;
    cand        = 0;
    for (int i = 1; i <= N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_W'(cand);
        grant[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= IDX_W'(N - 1);
    end else if (grant_valid) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/core_temp_monitor.sv
// Per-core thermal conditioner: one-entry hold per core, shared EMA update served
// round-robin, hot flag with hysteresis. Stale detection under CORE_TEMP_MON_STALE_EN.
module core_temp_monitor #(
  parameter int NUM_CORE          = 4,
  parameter int TEMP_SENSOR_WIDTH = soc_pkg::TEMP_SENSOR_WIDTH,
  parameter int AVG_SHIFT         = 3,
  parameter int HOT_THRESH        = soc_pkg::DEFAULT_HOT_THRESH,
  parameter int HOT_HYST          = soc_pkg::DEFAULT_HOT_HYST
`ifdef CORE_TEMP_MON_STALE_EN
  , parameter int STALE_CYCLES    = 1024
`endif
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  core_temp_monitor_if.slave                          sample_bus,
  output logic [NUM_CORE-1:0][TEMP_SENSOR_WIDTH-1:0]  temp_vec_o,
  output logic [NUM_CORE-1:0]                         hot_vec_o,
  output logic                                        any_hot_o,
  output logic [NUM_CORE-1:0]                         stale_vec_o
);
  import soc_pkg::*;

  localparam int W     = TEMP_SENSOR_WIDTH;
  localparam int IDX_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;
  localparam logic [W-1:0] HOT_ON  = W'(HOT_THRESH);
  localparam logic [W-1:0] HOT_OFF = W'(HOT_THRESH - HOT_HYST);

  logic [NUM_CORE-1:0]        hold_valid, primed, hot, accept, grant;
  logic [NUM_CORE-1:0][W-1:0] hold_data, avg;
  logic [IDX_W-1:0]           grant_idx;
  logic                       grant_valid;
  logic [W-1:0]               sel_sample, sel_avg, new_avg;
  logic signed [W:0]          diff, step, sum;
  logic                       new_hot;

  assign accept                  = sample_bus.sample_valid & ~hold_valid;
  assign sample_bus.sample_ready = ~hold_valid;

  core_temp_rr_arb #(.N(NUM_CORE), .IDX_W(IDX_W)) u_arb (
    .clk         (clk_i),
    .rst_n       (rst_ni),
    .req         (hold_valid),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // The new average lies between old average and sample, so W+1 signed bits never overflow.
  always_comb begin
    sel_sample = hold_data[grant_idx];
    sel_avg    = avg[grant_idx];
    diff       = $signed({1'b0, sel_sample}) - $signed({1'b0, sel_avg});
    step       = diff >>> AVG_SHIFT;
    sum        = $signed({1'b0, sel_avg}) + step;
    new_avg    = primed[grant_idx] ? W'(sum) : sel_sample;
    new_hot    = hot_next(hot[grant_idx], new_avg >= HOT_ON, new_avg < HOT_OFF);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_valid <= '0;
      hold_data  <= '0;
      primed     <= '0;
      avg        <= '0;
      hot        <= '0;
    end else begin
      for (int c = 0; c < NUM_CORE; c++) begin
        if (accept[c]) hold_data[c] <= sample_bus.sample[c];
      end
      hold_valid <= (hold_valid & ~grant) | accept;
      if (grant_valid) begin
        avg[grant_idx]    <= new_avg;
        primed[grant_idx] <= 1'b1;
        hot[grant_idx]    <= new_hot;
      end
    end
  end

  assign temp_vec_o = avg;
  assign hot_vec_o  = hot;
  assign any_hot_o  = |hot;

`ifdef CORE_TEMP_MON_STALE_EN
  localparam int SW = $clog2(STALE_CYCLES + 1);
  localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);

  logic [NUM_CORE-1:0][SW-1:0] stale_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stale_cnt <= '0;
    end else begin
      for (int c = 0; c < NUM_CORE; c++) begin
        if (accept[c])                     stale_cnt[c] <= '0;
        else if (stale_cnt[c] != STALE_MAX) stale_cnt[c] <= stale_cnt[c] + SW'(1);
      end
    end
  end

  always_comb begin
    stale_vec_o = '0;
    for (int c = 0; c < NUM_CORE; c++) stale_vec_o[c] = (stale_cnt[c] == STALE_MAX);
  end
`else
  assign stale_vec_o = '0;
`endif

endmodule

// File: tb/tb_core_temp_monitor.sv
// Bench for core_temp_monitor: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model. Honours CORE_TEMP_MON_STALE_EN.
module tb_core_temp_monitor;
  import soc_pkg::*;

  localparam int N     = 4;
  localparam int W     = TEMP_SENSOR_WIDTH;
  localparam int SH    = 3;
  localparam int TH    = 800;
  localparam int HY    = 32;
  localparam int STALE = 1024;

  // clock / reset
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  core_temp_monitor_if #(.NUM_CORE(N), .W(W)) bus ();
  logic [N-1:0][W-1:0] temp_vec;
  logic [N-1:0]        hot_vec, stale_vec;
  logic                any_hot;

  core_temp_monitor #(
    .NUM_CORE(N), .TEMP_SENSOR_WIDTH(W), .AVG_SHIFT(SH), .HOT_THRESH(TH), .HOT_HYST(HY)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sample_bus  (bus),
    .temp_vec_o  (temp_vec),
    .hot_vec_o   (hot_vec),
    .any_hot_o   (any_hot),
    .stale_vec_o (stale_vec)
  );

  // scoreboard
  int          errors = 0;
  int          checks = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: per-core state as plain integers
  int           m_avg[N];
  int           m_hold_d[N];
  bit           m_hold_v[N];
  bit           m_primed[N];
  bit           m_hot[N];
  int           m_cnt[N];
  int           m_ptr;
  logic [N-1:0] m_acc;

  function automatic int ema(input int a, input int s);
    int d;
    d = s - a;
    if (d >= 0) return a + d / (1 << SH);
    return a - ((-d + (1 << SH) - 1) / (1 << SH));
  endfunction

  task automatic model_edge(input logic rst, input logic [N-1:0] v, input logic [N-1:0][W-1:0] d);
    int g;
    m_acc = '0;
    if (!rst) begin
      for (int c = 0; c < N; c++) begin
        m_avg[c] = 0; m_hold_d[c] = 0; m_hold_v[c] = 0;
        m_primed[c] = 0; m_hot[c] = 0; m_cnt[c] = 0;
      end
      m_ptr = N - 1;
      return;
    end
    for (int c = 0; c < N; c++) m_acc[c] = v[c] && !m_hold_v[c];
    g = -1;
    for (int i = 1; i <= N; i++) begin
      if (g < 0 && m_hold_v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
    end
    if (g >= 0) begin
      m_avg[g]    = m_primed[g] ? ema(m_avg[g], m_hold_d[g]) : m_hold_d[g];
      m_primed[g] = 1;
      if (m_avg[g] >= TH)          m_hot[g] = 1;
      else if (m_avg[g] < TH - HY) m_hot[g] = 0;
      m_hold_v[g] = 0;
      m_ptr       = g;
    end
    for (int c = 0; c < N; c++) begin
      if (m_acc[c]) begin
        m_hold_v[c] = 1;
        m_hold_d[c] = int'(d[c]);
        m_cnt[c]    = 0;
      end else if (m_cnt[c] < STALE) begin
        m_cnt[c]++;
      end
    end
  endtask

  task automatic check_outputs();
    bit any;
    any = 0;
    for (int c = 0; c < N; c++) begin
      check_val($sformatf("temp%0d", c),  32'(temp_vec[c]),         32'(m_avg[c]));
      check_val($sformatf("hot%0d", c),   32'(hot_vec[c]),          32'(m_hot[c]));
      check_val($sformatf("ready%0d", c), 32'(bus.sample_ready[c]), 32'(!m_hold_v[c]));
`ifdef CORE_TEMP_MON_STALE_EN
      check_val($sformatf("stale%0d", c), 32'(stale_vec[c]),        32'(m_cnt[c] == STALE));
`else
      check_val($sformatf("stale%0d", c), 32'(stale_vec[c]),        32'(0));
`endif
      any |= m_hot[c];
    end
    check_val("any_hot", 32'(any_hot), 32'(any));
  endtask

  // drivers
  task automatic cycle();
    model_edge(rst_n, bus.sample_valid, bus.sample);
    @(posedge clk);
    #1;
    check_outputs();
    bus.sample_valid = bus.sample_valid & ~m_acc;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) cycle();
    rst_n = 1'b1;
  endtask

  task automatic send(input int c, input int val);
    bus.sample_valid[c] = 1'b1;
    bus.sample[c]       = W'(val);
    for (int k = 0; k < 2 * N && bus.sample_valid[c]; k++) cycle();
    check_val("send_accept", 32'(bus.sample_valid[c]), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ema_in[3];
    int   hy_t[3];
    bit   hy_h[3];
    temp_t rnd_val;
    ema_in = '{400, 480, 405};
    hy_t   = '{787, 776, 766};
    hy_h   = '{1, 1, 0};

    rst_n            = 1'b0;
    bus.sample_valid = '0;
    bus.sample       = '0;

    // reset state
    do_reset(3);
    check_val("rst_ready", 32'(bus.sample_ready), 32'(4'hF));
    check_val("rst_temp",  32'(temp_vec),         32'(0));
    check_val("rst_hot",   32'(hot_vec),          32'(0));
    check_val("rst_stale", 32'(stale_vec),        32'(0));

    // EMA on core1
    exp_q.push_back(W'(400));
    exp_q.push_back(W'(410));
    exp_q.push_back(W'(409));
    for (int i = 0; i < 3; i++) begin
      send(1, ema_in[i]);
      cycle();
      check_val("ema_core1", 32'(temp_vec[1]), 32'(exp_q.pop_front()));
    end

    // arbitration order after reset
    do_reset(2);
    for (int c = 0; c < N; c++) begin
      bus.sample_valid[c] = 1'b1;
      bus.sample[c]       = W'(100 * (c + 1));
    end
    cycle();
    for (int k = 0; k < N; k++) begin
      cycle();
      check_val("arb_temp",  32'(temp_vec[k]),         32'(100 * (k + 1)));
      check_val("arb_ready", 32'(bus.sample_ready[k]), 32'(1));
      if (k < N - 1) check_val("arb_next_held", 32'(bus.sample_ready[k + 1]), 32'(0));
    end

    // hysteresis on core0
    do_reset(2);
    send(0, 800);
    cycle();
    check_val("hy_prime_hot", 32'(hot_vec[0]), 32'(1));
    check_val("hy_prime_any", 32'(any_hot),    32'(1));
    for (int i = 0; i < 3; i++) begin
      send(0, 700);
      cycle();
      check_val("hy_temp", 32'(temp_vec[0]), 32'(hy_t[i]));
      check_val("hy_hot",  32'(hot_vec[0]),  32'(hy_h[i]));
    end

    // stale detection
    do_reset(3);
    repeat (STALE - 1) cycle();
    check_val("stale_before", 32'(stale_vec), 32'(0));
    cycle();
`ifdef CORE_TEMP_MON_STALE_EN
    check_val("stale_all", 32'(stale_vec), 32'(4'hF));
`else
    check_val("stale_all", 32'(stale_vec), 32'(0));
`endif
    bus.sample_valid[2] = 1'b1;
    bus.sample[2]       = W'(123);
    cycle();
`ifdef CORE_TEMP_MON_STALE_EN
    check_val("stale_clear2", 32'(stale_vec), 32'(4'b1011));
`else
    check_val("stale_clear2", 32'(stale_vec), 32'(0));
`endif

    // reset mid-operation
    do_reset(2);
    send(3, 200);
    cycle();
    send(3, 300);
    check_val("mid_held", 32'(bus.sample_ready[3]), 32'(0));
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    check_val("mid_ready", 32'(bus.sample_ready[3]), 32'(1));
    check_val("mid_temp",  32'(temp_vec[3]),         32'(0));
    send(3, 50);
    cycle();
    check_val("mid_prime", 32'(temp_vec[3]), 32'(50));

    // random traffic with one reset pulse
    do_reset(2);
    for (int k = 0; k < 800; k++) begin
      for (int c = 0; c < N; c++) begin
        if (!bus.sample_valid[c] && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 1) rnd_val = W'($urandom_range(740, 860));
          else                           rnd_val = W'($urandom_range(0, (1 << W) - 1));
          bus.sample_valid[c] = 1'b1;
          bus.sample[c]       = rnd_val;
        end
      end
      rst_n = (k == 400) ? 1'b0 : 1'b1;
      cycle();
    end
    rst_n            = 1'b1;
    bus.sample_valid = '0;
    repeat (N + 2) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
